tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen_pkg.sv | 18 +
 rtl/tick_chan.sv | 52 +++++
 rtl/tick_gen.sv | 83 ++++++++
 tb/tb_tick_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults for the tick generator.
//   NCH_DEF     - default number of divider channels
//   CW_DEF      - default counter / divisor width
//   DEF_DIV_DEF - default divisor loaded at reset
//   CLK_HZ      - master clock frequency (50 MHz)
//   ch_width()  - channel-index width, never less than one bit
package tick_gen_pkg;

  localparam int NCH_DEF     = 3;
  localparam int CW_DEF      = 18;
  localparam int DEF_DIV_DEF = 2;
  localparam int CLK_HZ      = 50_000_000;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one divider channel.
//   clk, reset - master clock, async active-high reset
//   en         - count enable
//   upd        - apply new_div at the next wrap
//   new_div    - replacement divisor (already sanitised, never 0)
//   wrap       - combinational: this cycle ends a period (en && cnt==div-1)
//   tick       - registered one-cycle strobe, one per div enabled cycles
//   sq         - registered square wave, period 2*div
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          upd,
  input  logic [CW-1:0] new_div,
  output logic          wrap,
  output logic          tick,
  output logic          sq
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div;

  assign wrap = en && (cnt == div - CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      div  <= CW'(DEF_DIV);
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= wrap;
      if (en) begin
        if (wrap) begin
          cnt <= '0;
          sq  <= ~sq;
          // The new divisor only takes effect at a period boundary, so the
          // period in flight always completes with the old divisor.
          if (upd) div <= new_div;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH independent clock dividers with a shared divisor-update port.
//   clk, reset  - 50 MHz master clock, async active-high reset
//   en          - global count enable
//   cfg_valid   - divisor update request
//   cfg_ready   - update can be accepted this cycle
//   cfg_ch      - target channel index
//   cfg_div     - new divisor (0 is treated as 1)
//   tick[NCH]   - per-channel one-cycle strobe
//   sq[NCH]     - per-channel 50% duty divided clock
//
// Handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is low exactly while one update is pending; the pending update
// is applied (and cfg_ready returns high) on the target channel's next wrap.
// Out-of-range channels are accepted and dropped without going pending.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [CW-1:0]            cfg_div,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           sq
);

  localparam int CHW = ch_width(NCH);

  logic           pending;
  logic [CHW-1:0] sh_ch;
  logic [CW-1:0]  sh_div;
  logic           xfer;
  logic           ch_ok;
  logic [NCH-1:0] upd;
  logic [NCH-1:0] wrap;

  assign cfg_ready = ~pending;
  assign xfer      = cfg_valid && cfg_ready;
  assign ch_ok     = int'(cfg_ch) < NCH;

  // pending is only set by a transfer registered at this edge, so a wrap in
  // the transfer cycle sees pending=0 and the divisor waits a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      sh_ch   <= '0;
      sh_div  <= '0;
    end else if (xfer) begin
      if (ch_ok) begin
        pending <= 1'b1;
        sh_ch   <= cfg_ch;
        sh_div  <= (cfg_div == '0) ? CW'(1) : cfg_div;
      end
    end else if (|(upd & wrap)) begin
      pending <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign upd[i] = pending && (sh_ch == CHW'(i));

    tick_chan #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .upd     (upd[i]),
      .new_div (sh_div),
      .wrap    (wrap[i]),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed bench for tick_gen with NCH=3, CW=8, DEF_DIV=4.
// "edge k" means the k-th rising edge after reset is released; outputs are
// sampled 1 ns after each rising edge.
module tb_tick_gen;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DD  = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [2:0]    tick;
  logic [2:0]    sq;

  int total;
  int bad;

  tick_gen #(.NCH(NCH), .CW(CW), .DEF_DIV(DD)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .sq        (sq)
  );

  // clock/reset
  initial clk = 1'b0;
  always #10 clk = ~clk;  // 50 MHz

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // REQ-035
  task automatic test_reset();
    logic [2:0] et, es;
    reset = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    #1;
    total++;
    if (tick !== 3'b000 || sq !== 3'b000 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: tick=%b sq=%b rdy=%b want 000 000 1", tick, sq, cfg_ready);
    end
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      es = ((k / 4) % 2 == 1) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et || sq !== es || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_run edge %0d: tick=%b sq=%b rdy=%b want %b %b 1", k, tick, sq, cfg_ready, et, es);
      end
    end
  endtask

  // REQ-036, REQ-027
  task automatic test_update();
    logic [2:0] et;
    logic       er;
    do_reset();
    step();  // edge 1: cnt=1
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL update_ready_pre: rdy=%b want 1", cfg_ready);
    end
    for (int k = 2; k <= 13; k++) begin
      step();
      cfg_valid = 1'b0;
      et[0] = (k % 4 == 0);
      et[2] = (k % 4 == 0);
      et[1] = (k == 4 || k == 7 || k == 10 || k == 13);
      er    = !(k == 2 || k == 3);
      total++;
      if (tick !== et || cfg_ready !== er) begin
        bad++;
        $display("FAIL update edge %0d: tick=%b rdy=%b want %b %b", k, tick, cfg_ready, et, er);
      end
    end
  endtask

  // REQ-037, REQ-019
  task automatic test_edge_div();
    logic [2:0] et, es;
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    for (int k = 1; k <= 12; k++) begin
      step();
      cfg_valid = 1'b0;
      if (k == 4) begin
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
      end
      et[0] = (k % 4 == 0);
      es[0] = ((k / 4) % 2 == 1);
      et[2] = (k >= 4);
      es[2] = (k >= 4) && ((k - 3) % 2 == 1);
      et[1] = (k >= 8) || (k % 4 == 0);
      es[1] = (k >= 4 && k < 8) || (k >= 8 && ((k - 8) % 2 == 1));
      total++;
      if (tick !== et || sq !== es) begin
        bad++;
        $display("FAIL edge_div edge %0d: tick=%b sq=%b want %b %b", k, tick, sq, et, es);
      end
    end
  endtask

  // REQ-038, REQ-026, REQ-018
  task automatic test_enable();
    logic [2:0] et;
    logic       er, es0;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step();
      cfg_valid = 1'b0;
      if (k == 2) begin
        en = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
      end
      if (k == 7) en = 1'b1;
      et[0] = (k == 9 || k == 11 || k == 13);
      et[1] = (k == 9 || k == 13);
      et[2] = et[1];
      er    = !(k >= 3 && k <= 8);
      es0   = (k == 9 || k == 10 || k == 13);
      total++;
      if (tick !== et || cfg_ready !== er || sq[0] !== es0) begin
        bad++;
        $display("FAIL enable edge %0d: tick=%b rdy=%b sq0=%b want %b %b %b", k, tick, cfg_ready, sq[0], et, er, es0);
      end
    end
    en = 1'b1;
  endtask

  // REQ-039, REQ-025
  task automatic test_invalid();
    logic [2:0] et;
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      step();
      cfg_valid = 1'b0;
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL invalid_ch edge %0d: tick=%b rdy=%b want %b 1", k, tick, cfg_ready, et);
      end
    end
  endtask

  // REQ-040, REQ-030
  task automatic test_async_reset();
    logic [2:0] et;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      cfg_valid = 1'b0;
      if (k == 4) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
      end
    end
    total++;
    if (sq !== 3'b111 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_pre: sq=%b rdy=%b want 111 0", sq, cfg_ready);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (tick !== 3'b000 || sq !== 3'b000 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_now: tick=%b sq=%b rdy=%b want 000 000 1", tick, sq, cfg_ready);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      et = (k % 4 == 0) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL async_after edge %0d: tick=%b rdy=%b want %b 1", k, tick, cfg_ready, et);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_update();
    test_edge_div();
    test_enable();
    test_invalid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
